// File: rtl/l2_port_arbiter.sv
// Two-port round-robin arbiter serializing L1 block requests onto the shared L2 interface.
// Define L2_ARB_FIXED_PRIO_EN to give port 1 (data L1) fixed priority on ties.
module l2_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned BLOCK_SIZE = 32,
    localparam int unsigned BW = BLOCK_SIZE * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [BW-1:0]         p0_wdata,
    input  logic                  p0_read,
    input  logic                  p0_write,
    output logic [BW-1:0]         p0_rdata,
    output logic                  p0_ready,
    output logic                  p0_hit,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [BW-1:0]         p1_wdata,
    input  logic                  p1_read,
    input  logic                  p1_write,
    output logic [BW-1:0]         p1_rdata,
    output logic                  p1_ready,
    output logic                  p1_hit,
    output logic [ADDR_WIDTH-1:0] l2_addr,
    output logic [BW-1:0]         l2_wdata,
    output logic                  l2_read,
    output logic                  l2_write,
    input  logic [BW-1:0]         l2_rdata,
    input  logic                  l2_ready,
    input  logic                  l2_hit
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic                  op_rd_q, op_rd_d;
    logic                  op_wr_q, op_wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BW-1:0]         wdata_q, wdata_d;
    logic [BW-1:0]         p0_rdata_q, p0_rdata_d;
    logic [BW-1:0]         p1_rdata_q, p1_rdata_d;
    logic                  p0_hit_q, p0_hit_d;
    logic                  p1_hit_q, p1_hit_d;
    logic                  p0_ready_q, p0_ready_d;
    logic                  p1_ready_q, p1_ready_d;

    logic req0, req1, tie_pick, sel;

    assign req0 = p0_read | p0_write;
    assign req1 = p1_read | p1_write;

`ifdef L2_ARB_FIXED_PRIO_EN
    assign tie_pick = 1'b1;
`else
    assign tie_pick = ~last_grant_q;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        op_rd_d      = op_rd_q;
        op_wr_d      = op_wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        p0_hit_d     = p0_hit_q;
        p1_hit_d     = p1_hit_q;
        p0_ready_d   = p0_ready_q;
        p1_ready_d   = p1_ready_q;
        sel          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req0 | req1) begin
                    sel     = (req0 & req1) ? tie_pick : req1;
                    grant_d = sel;
                    addr_d  = sel ? p1_addr : p0_addr;
                    wdata_d = sel ? p1_wdata : p0_wdata;
                    // Write takes precedence when both read and write are asserted
                    op_wr_d = sel ? p1_write : p0_write;
                    op_rd_d = sel ? (p1_read & ~p1_write) : (p0_read & ~p0_write);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (l2_ready) begin
                    if (grant_q) begin
                        p1_rdata_d = l2_rdata;
                        p1_hit_d   = l2_hit;
                        p1_ready_d = 1'b1;
                    end else begin
                        p0_rdata_d = l2_rdata;
                        p0_hit_d   = l2_hit;
                        p0_ready_d = 1'b1;
                    end
                    last_grant_d = grant_q;
                    state_d      = StDone;
                end
            end
            StDone: begin
                p0_ready_d = 1'b0;
                p1_ready_d = 1'b0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            op_rd_q      <= 1'b0;
            op_wr_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
            p0_hit_q     <= 1'b0;
            p1_hit_q     <= 1'b0;
            p0_ready_q   <= 1'b0;
            p1_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            op_rd_q      <= op_rd_d;
            op_wr_q      <= op_wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
            p0_hit_q     <= p0_hit_d;
            p1_hit_q     <= p1_hit_d;
            p0_ready_q   <= p0_ready_d;
            p1_ready_q   <= p1_ready_d;
        end
    end

    // Gated by l2_ready so the L2 never restarts a lookup in its completion cycle
    assign l2_read  = (state_q == StBusy) & op_rd_q & ~l2_ready;
    assign l2_write = (state_q == StBusy) & op_wr_q & ~l2_ready;
    assign l2_addr  = addr_q;
    assign l2_wdata = wdata_q;
    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;
    assign p0_hit   = p0_hit_q;
    assign p1_hit   = p1_hit_q;
    assign p0_ready = p0_ready_q;
    assign p1_ready = p1_ready_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Randomized self-checking bench for l2_port_arbiter with a transaction-level reference model.
module tb_l2_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 11;
    localparam int BS = 32;
    localparam int BW = DW * BS;

    logic          clk, rst_n;
    logic [AW-1:0] req_addr [2];
    logic [BW-1:0] req_wdata[2];
    logic          req_rd   [2];
    logic          req_wr   [2];
    logic [BW-1:0] p0_rdata, p1_rdata, l2_wdata, l2_rdata;
    logic          p0_ready, p1_ready, p0_hit, p1_hit;
    logic [AW-1:0] l2_addr;
    logic          l2_read, l2_write, l2_ready, l2_hit;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            last_grant_m;
    logic [BW-1:0] exp_rdata[2];
    logic          exp_hit  [2];
    int            winners[$];
    int            cfg_lat;
    int            cfg_hit;
    bit            cfg_data_en;
    logic [BW-1:0] cfg_data;

    l2_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_addr(req_addr[0]), .p0_wdata(req_wdata[0]), .p0_read(req_rd[0]),
        .p0_write(req_wr[0]), .p0_rdata(p0_rdata), .p0_ready(p0_ready), .p0_hit(p0_hit),
        .p1_addr(req_addr[1]), .p1_wdata(req_wdata[1]), .p1_read(req_rd[1]),
        .p1_write(req_wr[1]), .p1_rdata(p1_rdata), .p1_ready(p1_ready), .p1_hit(p1_hit),
        .l2_addr(l2_addr), .l2_wdata(l2_wdata), .l2_read(l2_read), .l2_write(l2_write),
        .l2_rdata(l2_rdata), .l2_ready(l2_ready), .l2_hit(l2_hit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    function automatic logic [BW-1:0] rand_blk();
        logic [BW-1:0] b;
        for (int i = 0; i < BS; i++) b[i*DW +: DW] = $urandom;
        return b;
    endfunction

    // Winner per the arbitration rules, from the model's own last-grant record
    function automatic int pick(input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef L2_ARB_FIXED_PRIO_EN
            return 1;
`else
            return 1 - last_grant_m;
`endif
        end
        return r0 ? 0 : 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_req(input int p);
        int op;
        op = int'($urandom_range(3, 1));
        req_rd[p]    = op[0];
        req_wr[p]    = op[1];
        req_addr[p]  = AW'($urandom);
        req_wdata[p] = rand_blk();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int p = 0; p < 2; p++) begin
            req_rd[p] = 1'b0; req_wr[p] = 1'b0; req_addr[p] = '0; req_wdata[p] = '0;
            exp_rdata[p] = '0; exp_hit[p] = 1'b0;
        end
        l2_ready = 1'b0; l2_hit = 1'b0; l2_rdata = '0;
        last_grant_m = 1;
        cfg_lat = -1; cfg_hit = -1; cfg_data_en = 1'b0;
        winners.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Runs n transactions starting in an IDLE cycle; ends at the start of the next IDLE cycle
    task automatic run_txns(input int n, input bit add_new, input bit force_both);
        for (int t = 0; t < n; t++) begin
            int            w, lat;
            logic          exp_rd, exp_wr, hit;
            logic [AW-1:0] a;
            logic [BW-1:0] wd, data;
            if (add_new)
                for (int p = 0; p < 2; p++)
                    if (!(req_rd[p] | req_wr[p]) && (force_both || $urandom_range(1, 0) == 1))
                        new_req(p);
            if (!(req_rd[0] | req_wr[0] | req_rd[1] | req_wr[1]))
                new_req(int'($urandom_range(1, 0)));
            l2_ready = ($urandom_range(3, 0) == 0);
            l2_rdata = rand_blk();
            l2_hit   = 1'b1;
            w      = pick(req_rd[0] | req_wr[0], req_rd[1] | req_wr[1]);
            exp_wr = req_wr[w];
            exp_rd = req_rd[w] & ~req_wr[w];
            a      = req_addr[w];
            wd     = req_wdata[w];
            @(negedge clk);
            checks++;
            if ({l2_read, l2_write, p0_ready, p1_ready} !== 4'b0) begin
                errors++;
                $display("FAIL idle_quiet: got rd/wr/rdy0/rdy1 %b want 0000",
                         {l2_read, l2_write, p0_ready, p1_ready});
            end
            step();
            l2_ready = 1'b0;
            @(negedge clk);
            checks++;
            if ({l2_addr, l2_read, l2_write} !== {a, exp_rd, exp_wr} || l2_wdata !== wd) begin
                errors++;
                $display("FAIL l2_request p%0d: got addr %h rd %b wr %b wdata %h want %h %b %b %h",
                         w, l2_addr, l2_read, l2_write, l2_wdata[127:0], a, exp_rd, exp_wr,
                         wd[127:0]);
            end
            lat = (cfg_lat > 0) ? cfg_lat : int'($urandom_range(4, 1));
            for (int i = 1; i < lat; i++) begin
                step();
                @(negedge clk);
                checks++;
                if ({l2_addr, l2_read, l2_write} !== {a, exp_rd, exp_wr} || l2_wdata !== wd) begin
                    errors++;
                    $display("FAIL busy_hold cyc %0d: got addr %h rd %b wr %b want %h %b %b",
                             i, l2_addr, l2_read, l2_write, a, exp_rd, exp_wr);
                end
            end
            step();
            data = cfg_data_en ? cfg_data : rand_blk();
            hit  = (cfg_hit < 0) ? 1'($urandom_range(1, 0)) : cfg_hit[0];
            l2_ready = 1'b1; l2_rdata = data; l2_hit = hit;
            @(negedge clk);
            checks++;
            if ({l2_read, l2_write, p0_ready, p1_ready} !== 4'b0) begin
                errors++;
                $display("FAIL ready_gate: got rd/wr/rdy0/rdy1 %b want 0000",
                         {l2_read, l2_write, p0_ready, p1_ready});
            end
            step();
            l2_ready = 1'b0; l2_rdata = rand_blk(); l2_hit = ~hit;
            exp_rdata[w] = data;
            exp_hit[w]   = hit;
            last_grant_m = w;
            winners.push_back(w);
            @(negedge clk);
            checks++;
            if ({p0_ready, p1_ready} !== ((w == 0) ? 2'b10 : 2'b01)
                || {p0_hit, p1_hit} !== {exp_hit[0], exp_hit[1]}) begin
                errors++;
                $display("FAIL done_pulse p%0d: got rdy %b%b hit %b%b want rdy %b hit %b%b", w,
                         p0_ready, p1_ready, p0_hit, p1_hit, (w == 0) ? 2'b10 : 2'b01,
                         exp_hit[0], exp_hit[1]);
            end
            checks++;
            if (p0_rdata !== exp_rdata[0] || p1_rdata !== exp_rdata[1]) begin
                errors++;
                $display("FAIL done_rdata: got p0 %h p1 %h want p0 %h p1 %h (low 128b)",
                         p0_rdata[127:0], p1_rdata[127:0], exp_rdata[0][127:0],
                         exp_rdata[1][127:0]);
            end
            req_rd[w] = 1'b0;
            req_wr[w] = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({l2_read, l2_write, p0_ready, p1_ready, p0_hit, p1_hit} !== 6'b0 || l2_addr !== '0
            || l2_wdata !== '0 || p0_rdata !== '0 || p1_rdata !== '0) begin
            errors++;
            $display("FAIL reset_state: got ctl %b addr %h want 000000 000",
                     {l2_read, l2_write, p0_ready, p1_ready, p0_hit, p1_hit}, l2_addr);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        req_rd[0] = 1'b1; req_addr[0] = 11'h040; req_wdata[0] = rand_blk();
        cfg_lat = 2; cfg_hit = 1; cfg_data_en = 1'b1; cfg_data = {BS{32'hA5A5_A5A5}};
        run_txns(1, 1'b0, 1'b0);
        checks++;
        if (winners.size() != 1 || winners[0] != 0) begin
            errors++;
            $display("FAIL single_grant: got %0d grants want 1 to p0", winners.size());
        end
    endtask

    task automatic test_tie_and_write();
        int exp0;
        do_reset();
        req_rd[0] = 1'b1; req_addr[0] = 11'h040; req_wdata[0] = rand_blk();
        req_wr[1] = 1'b1; req_addr[1] = 11'h7E0; req_wdata[1] = rand_blk();
`ifdef L2_ARB_FIXED_PRIO_EN
        exp0 = 1;
`else
        exp0 = 0;
`endif
        run_txns(2, 1'b0, 1'b0);
        checks++;
        if (winners.size() != 2 || winners[0] != exp0 || winners[1] != 1 - exp0) begin
            errors++;
            $display("FAIL tie_order: got %0d,%0d want %0d,%0d", winners[0], winners[1], exp0,
                     1 - exp0);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_txns(6, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            int e;
`ifdef L2_ARB_FIXED_PRIO_EN
            e = 1;
`else
            e = i % 2;
`endif
            checks++;
            if (winners[i] != e) begin
                errors++;
                $display("FAIL b2b_grant %0d: got p%0d want p%0d", i, winners[i], e);
            end
        end
    endtask

    task automatic test_read_miss();
        do_reset();
        req_rd[0] = 1'b1; req_addr[0] = AW'($urandom); req_wdata[0] = rand_blk();
        cfg_lat = 20; cfg_hit = 0;
        run_txns(1, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (p0_ready !== 1'b0 || p0_hit !== 1'b0) begin
            errors++;
            $display("FAIL miss_pulse_len: got rdy %b hit %b want 0 0", p0_ready, p0_hit);
        end
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        req_wr[0] = 1'b1; req_addr[0] = 11'h155; req_wdata[0] = rand_blk();
        step();
        @(negedge clk);
        checks++;
        if (l2_write !== 1'b1) begin
            errors++;
            $display("FAIL pre_abort_write: got %b want 1", l2_write);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({l2_read, l2_write, p0_ready, p1_ready, p0_hit, p1_hit} !== 6'b0
            || l2_addr !== '0 || l2_wdata !== '0) begin
            errors++;
            $display("FAIL async_abort: got ctl %b addr %h want 000000 000",
                     {l2_read, l2_write, p0_ready, p1_ready, p0_hit, p1_hit}, l2_addr);
        end
        do_reset();
        req_rd[1] = 1'b1; req_addr[1] = 11'h2A3; req_wdata[1] = rand_blk();
        run_txns(1, 1'b0, 1'b0);
    endtask

    task automatic test_rw_both();
        do_reset();
        req_rd[1] = 1'b1; req_wr[1] = 1'b1; req_addr[1] = 11'h3C1; req_wdata[1] = rand_blk();
        step();
        @(negedge clk);
        checks++;
        if ({l2_read, l2_write} !== 2'b01) begin
            errors++;
            $display("FAIL rw_both_op: got rd %b wr %b want 0 1", l2_read, l2_write);
        end
        do_reset();
        req_rd[0] = 1'b1; req_wr[0] = 1'b1; req_addr[0] = 11'h011; req_wdata[0] = rand_blk();
        run_txns(1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        do_reset();
        run_txns(60, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_single_read();
        test_tie_and_write();
        test_back_to_back();
        test_read_miss();
        test_reset_mid_busy();
        test_rw_both();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
